// File: rtl/gamma_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : gamma_lut_loader
// Brief    : Loads gamma LUT entries into a shadow bank and swaps banks at a
//            frame boundary once the load has been committed.
// Revision : 1.0 - initial release
// ============================================================================
module gamma_lut_loader #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic [1:0]            cfg_plane,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    input  logic                  cfg_commit,
    input  logic                  frame_start,
    output logic                  lut_we,
    output logic [1:0]            lut_plane,
    output logic [ADDR_WIDTH:0]   lut_addr,
    output logic [DATA_WIDTH-1:0] lut_wdata,
    output logic                  active_bank,
    output logic                  swap_done,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [ADDR_WIDTH+1:0] load_count
);

    localparam int c_CNT_W = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_active_bank;
    logic                  r_shadow;
    logic                  r_lut_we;
    logic [1:0]            r_lut_plane;
    logic [ADDR_WIDTH:0]   r_lut_addr;
    logic [DATA_WIDTH-1:0] r_lut_wdata;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_bad_plane;
    logic                  w_wr;
    logic                  w_restart;
    logic                  w_err_set;
    logic                  w_commit_nonzero;
    logic [c_CNT_W-1:0]    w_count_base;
    logic [c_CNT_W-1:0]    w_count_nxt;

    assign w_ready     = (r_state == ST_LOAD);
    assign w_accept    = cfg_valid & w_ready;
    assign w_bad_plane = (cfg_plane == 2'd3);
    assign w_wr        = w_accept & ~w_bad_plane;
    assign w_restart   = cfg_start & ((r_state == ST_IDLE) | (r_state == ST_LOAD));
    assign w_err_set   = (cfg_valid & ~w_ready) | (w_accept & w_bad_plane);

    // A write in the same cycle as cfg_commit counts toward the commit decision.
    assign w_commit_nonzero = (r_count != '0) | w_wr;

    // A restart clears the count; a same-cycle write becomes the first entry of the new load.
    always_comb begin
        w_count_base = w_restart ? '0 : r_count;
        w_count_nxt  = w_count_base;
        if (w_wr && !(&w_count_base)) begin
            w_count_nxt = w_count_base + c_CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    w_state_nxt = ST_LOAD;
                end else if (cfg_commit) begin
                    w_state_nxt = w_commit_nonzero ? ST_ARMED : ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active_bank <= 1'b0;
            r_shadow      <= 1'b0;
            r_count       <= '0;
            r_err         <= 1'b0;
        end else begin
            if (r_state == ST_SWAP) begin
                r_active_bank <= ~r_active_bank;
            end
            if (cfg_start && (r_state == ST_IDLE)) begin
                r_shadow <= ~r_active_bank;
            end
            r_count <= w_count_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_restart) begin
                r_err <= 1'b0;
            end
        end
    end

    // Write port is a pure one-cycle pipeline of the accepted entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lut_we    <= 1'b0;
            r_lut_plane <= 2'd0;
            r_lut_addr  <= '0;
            r_lut_wdata <= '0;
        end else begin
            r_lut_we <= w_wr;
            if (w_wr) begin
                r_lut_plane <= cfg_plane;
                r_lut_addr  <= {r_shadow, cfg_addr};
                r_lut_wdata <= cfg_data;
            end
        end
    end

    assign cfg_ready   = w_ready;
    assign lut_we      = r_lut_we;
    assign lut_plane   = r_lut_plane;
    assign lut_addr    = r_lut_addr;
    assign lut_wdata   = r_lut_wdata;
    assign active_bank = r_active_bank;
    assign swap_done   = (r_state == ST_SWAP);
    assign busy        = (r_state != ST_IDLE);
    assign cfg_err     = r_err;
    assign load_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gamma_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gamma_lut_loader
// Brief    : Table-driven directed checks of gamma_lut_loader plus hand-written
//            reset and counter-saturation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gamma_lut_loader;

    logic        clk;
    logic        rstn;
    logic        cfg_start, cfg_valid, cfg_commit, frame_start;
    logic [1:0]  cfg_plane;
    logic [11:0] cfg_addr, cfg_data;
    logic        cfg_ready, lut_we, active_bank, swap_done, busy, cfg_err;
    logic [1:0]  lut_plane;
    logic [12:0] lut_addr;
    logic [11:0] lut_wdata;
    logic [13:0] load_count;

    // Narrow instance so the load counter can reach saturation quickly.
    logic        s_start, s_valid, s_commit, s_fs;
    logic [1:0]  s_plane;
    logic [1:0]  s_addr;
    logic [3:0]  s_data;
    logic        s_ready, s_we, s_bank, s_swap, s_busy, s_err;
    logic [1:0]  s_lut_plane;
    logic [2:0]  s_lut_addr;
    logic [3:0]  s_wdata;
    logic [3:0]  s_count;

    int checks = 0;
    int errors = 0;

    gamma_lut_loader dut (
        .clk(clk), .rstn(rstn),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_plane(cfg_plane),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .cfg_commit(cfg_commit), .frame_start(frame_start),
        .lut_we(lut_we), .lut_plane(lut_plane), .lut_addr(lut_addr),
        .lut_wdata(lut_wdata), .active_bank(active_bank), .swap_done(swap_done),
        .busy(busy), .cfg_err(cfg_err), .load_count(load_count)
    );

    gamma_lut_loader #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut_sat (
        .clk(clk), .rstn(rstn),
        .cfg_start(s_start), .cfg_valid(s_valid), .cfg_plane(s_plane),
        .cfg_addr(s_addr), .cfg_data(s_data), .cfg_ready(s_ready),
        .cfg_commit(s_commit), .frame_start(s_fs),
        .lut_we(s_we), .lut_plane(s_lut_plane), .lut_addr(s_lut_addr),
        .lut_wdata(s_wdata), .active_bank(s_bank), .swap_done(s_swap),
        .busy(s_busy), .cfg_err(s_err), .load_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st, v;
        logic [1:0]  pl;
        logic [11:0] a, d;
        logic        c, fs;
        logic        e_we;
        logic [12:0] e_addr;
        logic [11:0] e_wd;
        logic [1:0]  e_pl;
        logic [13:0] e_cnt;
        logic        e_err, e_busy, e_rdy, e_bank, e_sw;
    } vec_t;

    vec_t  vecs [40];
    string vname [40];
    int    nv = 0;

    task automatic add(input string nm, input logic st, input logic v, input logic [1:0] pl,
                       input logic [11:0] a, input logic [11:0] d, input logic c, input logic fs,
                       input logic e_we, input logic [12:0] e_addr, input logic [11:0] e_wd,
                       input logic [1:0] e_pl, input logic [13:0] e_cnt, input logic e_err,
                       input logic e_busy, input logic e_rdy, input logic e_bank, input logic e_sw);
        vec_t t;
        t.st = st; t.v = v; t.pl = pl; t.a = a; t.d = d; t.c = c; t.fs = fs;
        t.e_we = e_we; t.e_addr = e_addr; t.e_wd = e_wd; t.e_pl = e_pl; t.e_cnt = e_cnt;
        t.e_err = e_err; t.e_busy = e_busy; t.e_rdy = e_rdy; t.e_bank = e_bank; t.e_sw = e_sw;
        vecs[nv]  = t;
        vname[nv] = nm;
        nv++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_start = 0; cfg_valid = 0; cfg_plane = 0; cfg_addr = 0; cfg_data = 0;
        cfg_commit = 0; frame_start = 0;
    endtask

    initial begin
        idle_inputs();
        s_start = 0; s_valid = 0; s_plane = 0; s_addr = 0; s_data = 0; s_commit = 0; s_fs = 0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", lut_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_bank", active_bank, 0);
        chk("rst_count", load_count, 0);
        chk("rst_addr", lut_addr, 0);
        chk("rst_err", cfg_err, 0);
        @(negedge clk);
        rstn = 1'b1;

        //   name            st v pl a       d       c fs  we addr      wd      pl cnt  err busy rdy bank sw
        add("start",         1,0,0,12'h000,12'h000,0,0, 0,13'h0000,12'h000,0, 0,   0, 1, 1, 0, 0);
        add("wr0",           0,1,0,12'h000,12'h000,0,0, 1,13'h1000,12'h000,0, 1,   0, 1, 1, 0, 0);
        add("wr1",           0,1,0,12'h001,12'h123,0,0, 1,13'h1001,12'h123,0, 2,   0, 1, 1, 0, 0);
        add("wr2",           0,1,0,12'h002,12'hFFF,0,0, 1,13'h1002,12'hFFF,0, 3,   0, 1, 1, 0, 0);
        add("commit",        0,0,0,12'h000,12'h000,1,0, 0,13'h0000,12'h000,0, 3,   0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            add("armed_wait",0,0,0,12'h000,12'h000,0,0, 0,13'h0000,12'h000,0, 3,   0, 1, 0, 0, 0);
        add("frame",         0,0,0,12'h000,12'h000,0,1, 0,13'h0000,12'h000,0, 3,   0, 1, 0, 0, 1);
        add("post_swap",     0,0,0,12'h000,12'h000,0,0, 0,13'h0000,12'h000,0, 3,   0, 0, 0, 1, 0);
        add("idle_ignore",   0,0,0,12'h000,12'h000,1,1, 0,13'h0000,12'h000,0, 3,   0, 0, 0, 1, 0);
        add("start2",        1,0,0,12'h000,12'h000,0,0, 0,13'h0000,12'h000,0, 0,   0, 1, 1, 1, 0);
        add("wr_bank0",      0,1,1,12'h005,12'hABC,0,0, 1,13'h0005,12'hABC,1, 1,   0, 1, 1, 1, 0);
        add("plane3",        0,1,3,12'h007,12'h111,0,0, 0,13'h0000,12'h000,0, 1,   1, 1, 1, 1, 0);
        add("restart",       1,0,0,12'h000,12'h000,0,0, 0,13'h0000,12'h000,0, 0,   0, 1, 1, 1, 0);
        add("empty_commit",  0,0,0,12'h000,12'h000,1,0, 0,13'h0000,12'h000,0, 0,   0, 0, 0, 1, 0);
        add("no_swap",       0,0,0,12'h000,12'h000,0,1, 0,13'h0000,12'h000,0, 0,   0, 0, 0, 1, 0);
        add("start3",        1,0,0,12'h000,12'h000,0,0, 0,13'h0000,12'h000,0, 0,   0, 1, 1, 1, 0);
        add("wr_commit",     0,1,2,12'h00A,12'h055,1,0, 1,13'h000A,12'h055,2, 1,   0, 1, 0, 1, 0);
        add("armed_valid",   0,1,0,12'h003,12'h003,0,0, 0,13'h0000,12'h000,0, 1,   1, 1, 0, 1, 0);
        add("armed_ignore",  1,0,0,12'h000,12'h000,1,0, 0,13'h0000,12'h000,0, 1,   1, 1, 0, 1, 0);

        for (int i = 0; i < nv; i++) begin
            cfg_start = vecs[i].st; cfg_valid = vecs[i].v; cfg_plane = vecs[i].pl;
            cfg_addr = vecs[i].a; cfg_data = vecs[i].d; cfg_commit = vecs[i].c;
            frame_start = vecs[i].fs;
            @(posedge clk);
            #1;
            idle_inputs();
            chk({vname[i], "_we"}, lut_we, vecs[i].e_we);
            if (vecs[i].e_we) begin
                chk({vname[i], "_addr"}, lut_addr, vecs[i].e_addr);
                chk({vname[i], "_wdata"}, lut_wdata, vecs[i].e_wd);
                chk({vname[i], "_plane"}, lut_plane, vecs[i].e_pl);
            end
            chk({vname[i], "_count"}, load_count, vecs[i].e_cnt);
            chk({vname[i], "_err"}, cfg_err, vecs[i].e_err);
            chk({vname[i], "_busy"}, busy, vecs[i].e_busy);
            chk({vname[i], "_ready"}, cfg_ready, vecs[i].e_rdy);
            chk({vname[i], "_bank"}, active_bank, vecs[i].e_bank);
            chk({vname[i], "_swap"}, swap_done, vecs[i].e_sw);
        end

        // Asynchronous reset while ARMED with bank 1: outputs clear without a clock edge.
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_bank", active_bank, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", cfg_err, 0);
        chk("arst_count", load_count, 0);
        chk("arst_ready", cfg_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        frame_start = 1;
        @(posedge clk);
        #1;
        frame_start = 0;
        chk("arst_fs_swap", swap_done, 0);
        chk("arst_fs_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("arst_fs_bank", active_bank, 0);

        // Saturation of the narrow instance's 4-bit load counter.
        s_start = 1;
        @(posedge clk);
        #1;
        s_start = 0;
        chk("sat_start_busy", s_busy, 1);
        for (int i = 0; i < 17; i++) begin
            s_valid = 1; s_plane = 2'd1; s_addr = 2'(i); s_data = 4'(i);
            @(posedge clk);
            #1;
            chk("sat_count", s_count, (i + 1 > 15) ? 15 : i + 1);
            chk("sat_we", s_we, 1);
        end
        s_valid = 0;
        chk("sat_lut_addr", s_lut_addr, 3'b100);
        chk("sat_wdata", s_wdata, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
